// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, sequences a fixed
// latency per operation and raises busy so the hazard unit can stall HI/LO users.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic             accept;
  logic             done;
  logic             mtx_ok;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_wr;
  logic [CNT_W-1:0] res_cnt;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign accept = en && (state == IDLE) && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
  assign mtx_ok = en && (state == IDLE);
  assign done   = (state == RUN) && (cnt == '0);

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign quot_s = $signed(rs) / $signed(rt);
  assign rem_s  = $signed(rs) % $signed(rt);
  assign quot_u = rs / rt;
  assign rem_u  = rs % rt;

  // The whole result is settled at accept time; the countdown only models latency.
  // A zero divisor still occupies the full latency but leaves HI/LO alone.
  always_comb begin
    res_hi  = '0;
    res_lo  = '0;
    res_wr  = 1'b1;
    res_cnt = CNT_W'(MULT_LAT - 1);
    case (mdu_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi  = rem_s;
        res_lo  = quot_s;
        res_wr  = (rt != '0);
        res_cnt = CNT_W'(DIV_LAT - 1);
      end
      OP_DIVU: begin
        res_hi  = rem_u;
        res_lo  = quot_u;
        res_wr  = (rt != '0);
        res_cnt = CNT_W'(DIV_LAT - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt     <= res_cnt;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (mtx_ok && mdu_op == OP_MTHI) begin
        hi <= rs;
      end else if (mtx_ok && mdu_op == OP_MTLO) begin
        lo <= rs;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    md_out = '0;
    if (mdu_op == OP_MFHI)
      md_out = hi;
    else if (mdu_op == OP_MFLO)
      md_out = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-count reference model.
module tb_mdu_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  mdu_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mdu_op (mdu_op),
    .rs     (rs),
    .rt     (rt),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    en     = e;
    mdu_op = op;
    rs     = a;
    rt     = b;
  endtask

  // Idles the inputs and counts how many further cycles busy stays high (bounded).
  task automatic wait_done(output int n);
    n = 0;
    forever begin
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      if (!busy || n > 50) break;
      n++;
    end
  endtask

  // Reference model: HI/LO plus the number of busy cycles still owed.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_wr;
  int          m_left;

  always @(posedge clk) begin
    int a, b;
    int unsigned ua, ub;
    longint p;
    longint unsigned pu;
    logic [31:0] exp_md;
    a  = rs;
    b  = rt;
    ua = rs;
    ub = rt;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (en) begin
      case (mdu_op)
        4'd1: begin
          p = longint'(a) * longint'(b);
          {m_phi, m_plo} = p; m_wr = 1; m_left = MULT_LAT;
        end
        4'd2: begin
          pu = longint'(ua) * longint'(ub);
          {m_phi, m_plo} = pu; m_wr = 1; m_left = MULT_LAT;
        end
        4'd3: begin
          m_wr = (b != 0); m_left = DIV_LAT;
          if (m_wr) begin m_plo = a / b; m_phi = a % b; end
        end
        4'd4: begin
          m_wr = (ub != 0); m_left = DIV_LAT;
          if (m_wr) begin m_plo = ua / ub; m_phi = ua % ub; end
        end
        4'd5: m_hi = rs;
        4'd6: m_lo = rs;
        default: ;
      endcase
    end
    #1;
    exp_md = (mdu_op == 4'd7) ? m_hi : (mdu_op == 4'd8) ? m_lo : 32'd0;
    checkOutput("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
    checkOutput("model_hi", hi, m_hi);
    checkOutput("model_lo", lo, m_lo);
    checkOutput("model_md_out", md_out, exp_md);
  end

  initial begin
    int n;
    reset  = 1'b1;
    en     = 1'b0;
    mdu_op = 4'd0;
    rs     = '0;
    rt     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5);
    wait_done(n);
    checkOutput("mult_busy_cycles", n, 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFF1);

    applyStimulus(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(n);
    checkOutput("multu_hi", hi, 32'h0000_0001);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 4'd7, 32'd0, 32'd0);
    #1 checkOutput("mfhi_md_out", md_out, 32'h0000_0001);
    applyStimulus(1'b0, 4'd8, 32'd0, 32'd0);
    #1 checkOutput("mflo_no_en_md_out", md_out, 32'hFFFF_FFFE);

    applyStimulus(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    checkOutput("div_busy_cycles", n, 32'd10);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'd4, 32'd7, 32'd2);
    wait_done(n);
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd1);

    applyStimulus(1'b1, 4'd5, 32'h1234_5678, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 4'd4, 32'd9, 32'd0);
    wait_done(n);
    checkOutput("divzero_busy_cycles", n, 32'd10);
    checkOutput("divzero_hi", hi, 32'h1234_5678);
    checkOutput("divzero_lo", lo, 32'd3);

    applyStimulus(1'b1, 4'd1, 32'd7, 32'd6);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 4'd6, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(1'b1, 4'd3, 32'd100, 32'd3);
    wait_done(n);
    checkOutput("mult_busy_tail", n, 32'd2);
    checkOutput("ignored_ops_lo", lo, 32'd42);
    checkOutput("ignored_ops_hi", hi, 32'd0);
    applyStimulus(1'b0, 4'd1, 32'd5, 32'd5);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("en_low_no_start", {31'd0, busy}, 32'd0);

    applyStimulus(1'b1, 4'd3, 32'd100, 32'd7);
    repeat (3) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (12) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("abort_late_hi", hi, 32'd0);
    checkOutput("abort_late_lo", lo, 32'd0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(0, 16)) - 32'd8;
        default: b = $urandom;
      endcase
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      applyStimulus($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)), a, b);
      reset = ($urandom_range(0, 99) < 2);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its own sequencing controller and HI/LO register file, placed in the E stage beside the ALU.
- Accepts one operation per issue, counts down a fixed latency, and exposes busy to the hazard unit for stalling later HI/LO users.
- Serves MFHI/MFLO reads through a combinational result port.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU
- DIV_LAT, 10, busy cycles for DIV/DIVU

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- en  input  1  E-stage instruction valid; low for bubble/flush
- mdu_op  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 NOP
- rs  input  32  operand A (dividend / multiplicand / MTx source)
- rt  input  32  operand B (divisor / multiplier)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- md_out  output  32  MFHI→hi, MFLO→lo, otherwise 0; combinational

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, pending results=0, state IDLE. Reset asserted mid-operation aborts it and discards the result.
- State machine has two states:
  - IDLE: busy=0.
  - RUN: busy=1, counter decrements every cycle.
- Accept condition: en=1 and busy=0 and mdu_op in 1..4. On that edge:
  - Operands are captured and the full result is computed into pending registers (product, or quotient/remainder).
  - Counter is loaded with MULT_LAT-1 or DIV_LAT-1, and state goes to RUN.
- RUN: on the edge where counter==0, hi/lo are written from pending and state returns to IDLE.
  - busy is therefore high for exactly MULT_LAT (5) or DIV_LAT (10) cycles after the accepting edge.
  - New hi/lo are visible in the first cycle busy is low.
- Arithmetic:
  - MULT: signed 32x32→64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32→64.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero (rt==0): the op still runs the full DIV_LAT cycles, but hi/lo retain their prior values at completion.
- MTHI/MTLO: with en=1 and busy=0, hi (or lo) ← rs on that edge, no busy. Ignored while busy.
- MFHI/MFLO: pure read through md_out, independent of en. While busy, md_out shows the old hi/lo; the hazard unit must stall.
- Any op arriving while busy=1 (including a second start) is ignored, with no effect on state or counter. The hazard unit guarantees that no MDU instruction enters E while busy or while an MDU start is in E.
- en=0 suppresses accept and MTx writes; an in-flight operation continues unaffected (a flush does not cancel it).
- No same-cycle completion/accept overlap: accept requires busy=0, and busy stays 1 through the completion edge.

Test Plan:
- MULT with rs=0xFFFFFFFD (-3), rt=5 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- MULTU with rs=0xFFFFFFFF, rt=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. MFHI then gives md_out=0x00000001.
- DIV with rs=0xFFFFFFF9 (-7), rt=2 → busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with rs=7, rt=2 → lo=3, hi=1.
- MTHI rs=0x12345678 → hi updated next edge with busy=0. Then DIVU rs=9, rt=0 → busy 10 cycles, after which hi=0x12345678 and lo is unchanged.
- MULT started, then MTLO and DIV issued during cycles 2-3 of busy → both ignored; the MULT result completes at cycle 5 unaltered. Also check that en=0 with mdu_op=1 starts nothing.
- DIV started, reset asserted at busy cycle 4 → next cycle busy=0, hi=0, lo=0, and no later write occurs.
